sa_buff_stream_reader: RTL and testbench



---
 rtl/sa_buff_stream_reader.sv | 158 +++++++++++++++
 tb/tb_sa_buff_stream_reader.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/sa_buff_stream_reader.sv
// sa_buff_stream_reader: walks a flat buffer address range and
// streams the read data out through a 3-entry skid FIFO.
module sa_buff_stream_reader #(
  parameter int SRAM_DEPTH = 1024,
  parameter int BAND_WIDTH = 16,
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 16,
  localparam int ADDR_W =
    $clog2(SRAM_DEPTH) + $clog2(BAND_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [ADDR_W-1:0]     base_addr_i,
  input  logic [LEN_WIDTH-1:0]  len_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  enb,
  output logic [ADDR_W-1:0]     addrb,
  input  logic [DATA_WIDTH-1:0] dob,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  input  logic                  m_ready
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_W-1:0]     base_q, base_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [LEN_WIDTH-1:0]  iss_q, iss_d;
  logic [LEN_WIDTH-1:0]  acc_q, acc_d;
  logic [LEN_WIDTH-1:0]  cap_q, cap_d;
  logic                  enb_q, enb_d;
  logic                  infl_q, infl_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [1:0]            cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] dat_q [3];
  logic [DATA_WIDTH-1:0] dat_d [3];
  logic [2:0]            lst_q, lst_d;
  logic                  pop;
  logic [1:0]            wr_idx;
  logic                  room;

  // Next-state, issue decision and FIFO shift/capture.
  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    len_d   = len_q;
    pop     = (cnt_q != 2'd0) && m_ready;
    wr_idx  = cnt_q - {1'b0, pop};
    cnt_d   = cnt_q + {1'b0, infl_q} - {1'b0, pop};
    dat_d   = dat_q;
    lst_d   = lst_q;
    if (pop) begin
      dat_d[0] = dat_q[1];
      dat_d[1] = dat_q[2];
      lst_d    = {1'b0, lst_q[2:1]};
    end
    if (infl_q) begin
      dat_d[wr_idx] = dob;
      lst_d[wr_idx] = (cap_q == (len_q - LEN_WIDTH'(1)));
    end
    cap_d  = cap_q + LEN_WIDTH'(infl_q);
    acc_d  = acc_q + LEN_WIDTH'(pop);
    infl_d = enb_q;
    // Reads already in the pipe count against FIFO space,
    // so the FIFO can never take more than 3 entries.
    room  = ({1'b0, cnt_d} + {2'b00, enb_q}) < 3'd3;
    enb_d = (state_q == RUN) && (iss_q < len_q) && room;
    iss_d = iss_q + LEN_WIDTH'(enb_d);
    addr_d = addr_q;
    if (enb_d) begin
      addr_d = base_q + ADDR_W'(iss_q);
    end
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          if (len_i != '0) begin
            state_d = RUN;
            base_d  = base_addr_i;
            len_d   = len_i;
            iss_d   = '0;
            acc_d   = '0;
            cap_d   = '0;
          end else begin
            state_d = DONE;
          end
        end
      end
      RUN: begin
        if (iss_q == len_q) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (acc_d == len_q) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, counters, read port and FIFO registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      base_q  <= '0;
      len_q   <= '0;
      iss_q   <= '0;
      acc_q   <= '0;
      cap_q   <= '0;
      enb_q   <= 1'b0;
      infl_q  <= 1'b0;
      addr_q  <= '0;
      cnt_q   <= '0;
      lst_q   <= '0;
      for (int i = 0; i < 3; i++) begin
        dat_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      len_q   <= len_d;
      iss_q   <= iss_d;
      acc_q   <= acc_d;
      cap_q   <= cap_d;
      enb_q   <= enb_d;
      infl_q  <= infl_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      lst_q   <= lst_d;
      dat_q   <= dat_d;
      assert (!(cnt_q == 2'd3 && infl_q && !pop));
    end
  end

  assign busy_o  = (state_q == RUN) || (state_q == DRAIN);
  assign done_o  = (state_q == DONE);
  assign enb     = enb_q;
  assign addrb   = addr_q;
  assign m_valid = (cnt_q != 2'd0);
  assign m_data  = dat_q[0];
  assign m_last  = m_valid && lst_q[0];

endmodule

// File: tb/tb_sa_buff_stream_reader.sv
// tb_sa_buff_stream_reader: directed vectors for the
// buffer stream reader with a 1-cycle-latency buffer model.
module tb_sa_buff_stream_reader;

  localparam int AW = 14;
  localparam int DW = 8;
  localparam int LW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start_i = 1'b0;
  logic [AW-1:0] base_addr_i = '0;
  logic [LW-1:0] len_i = '0;
  logic          busy_o;
  logic          done_o;
  logic          enb;
  logic [AW-1:0] addrb;
  logic [DW-1:0] dob = '0;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic          m_ready = 1'b1;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [AW-1:0] base;
    logic [LW-1:0] len;
    int            lo_from;
    int            lo_to;
    int            poke;
    int            exp_done;
  } vec_t;

  vec_t vecs [7];

  sa_buff_stream_reader dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start_i),
    .base_addr_i (base_addr_i),
    .len_i       (len_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .enb         (enb),
    .addrb       (addrb),
    .dob         (dob),
    .m_valid     (m_valid),
    .m_data      (m_data),
    .m_last      (m_last),
    .m_ready     (m_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] mem_val(input logic [AW-1:0] a);
    return a[7:0] ^ {2'b00, a[13:8]};
  endfunction

  always @(posedge clk) begin
    if (enb) dob <= mem_val(addrb);
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_cmd(input vec_t v);
    int iss = 0;
    int pops = 0;
    int first_en = -1;
    int first_v = -1;
    int done_at = -1;
    logic held = 1'b0;
    logic [DW-1:0] hdata = '0;
    logic hlast = 1'b0;
    @(negedge clk);
    base_addr_i = v.base;
    len_i = v.len;
    start_i = 1'b1;
    m_ready = 1'b1;
    for (int c = 0; c < 80 && done_at < 0; c++) begin
      @(negedge clk);
      start_i = (c == v.poke);
      if (c == v.poke) begin
        base_addr_i = 14'h2AA;
        len_i = 16'd9;
      end
      m_ready = !(c >= v.lo_from && c <= v.lo_to);
      if (c == 0) chk("busy_after_start", busy_o, v.len != 0);
      if (enb) begin
        if (first_en < 0) first_en = c;
        chk("addrb", addrb, AW'(v.base + AW'(iss)));
        iss++;
        chk("outstanding_le_3", (iss - pops) <= 3, 1);
      end
      if (m_valid) begin
        if (first_v < 0) first_v = c;
        if (held) begin
          chk("hold_data", m_data, hdata);
          chk("hold_last", m_last, hlast);
        end
        if (m_ready) begin
          chk("m_data", m_data, mem_val(AW'(v.base + AW'(pops))));
          chk("m_last", m_last, pops == int'(v.len) - 1);
          pops++;
          held = 1'b0;
        end else begin
          held = 1'b1;
          hdata = m_data;
          hlast = m_last;
        end
      end
      if (done_o) begin
        done_at = c;
        chk("busy_at_done", busy_o, 0);
      end
    end
    chk("done_cycle", done_at, v.exp_done);
    chk("issued", iss, v.len);
    chk("popped", pops, v.len);
    if (v.len != 0) begin
      chk("first_enb", first_en, 1);
      chk("first_valid", first_v, 3);
    end
    @(negedge clk);
    chk("done_one_pulse", done_o, 0);
    chk("idle_busy", busy_o, 0);
    start_i = 1'b0;
    m_ready = 1'b1;
  endtask

  initial begin
    int dones;
    vec_t rv;
    vecs[0] = '{14'h0005, 16'd4, 100, -1, -1, 7};
    vecs[1] = '{14'h03FE, 16'd4, 100, -1, -1, 7};
    vecs[2] = '{14'h3FFF, 16'd2, 100, -1, -1, 5};
    vecs[3] = '{14'h0100, 16'd8, 4, 9, -1, 17};
    vecs[4] = '{14'h0123, 16'd0, 100, -1, -1, 0};
    vecs[5] = '{14'h0010, 16'd4, 100, -1, 2, 7};
    vecs[6] = '{14'h0020, 16'd1, 100, -1, -1, 4};

    #1 rst = 1'b1;
    #1;
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_enb", enb, 0);
    chk("rst_addrb", addrb, 0);
    chk("rst_valid", m_valid, 0);
    chk("rst_last", m_last, 0);
    chk("rst_data", m_data, 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      run_cmd(vecs[i]);
    end

    @(negedge clk);
    base_addr_i = 14'h0040;
    len_i = 16'd6;
    start_i = 1'b1;
    m_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      start_i = 1'b0;
    end
    chk("mid_enb", enb, 1);
    chk("mid_valid", m_valid, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", busy_o, 0);
    chk("arst_enb", enb, 0);
    chk("arst_addrb", addrb, 0);
    chk("arst_valid", m_valid, 0);
    chk("arst_last", m_last, 0);
    chk("arst_data", m_data, 0);
    @(negedge clk);
    rst = 1'b0;
    dones = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (done_o) dones++;
    end
    chk("no_done_after_rst", dones, 0);

    rv = '{14'h07F0, 16'd2, 100, -1, -1, 5};
    run_cmd(rv);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
